// File: rtl/booth_collect_pkg.sv
// Shared types and defaults for the Booth multiplier product collector.
package booth_collect_pkg;

    // Assembler phase: waiting for the high byte, or for the low byte
    typedef enum logic {
        S_HIGH = 1'b0,
        S_LOW  = 1'b1
    } collect_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 4;

endpackage

// File: rtl/booth_prod_fifo.sv
// Show-ahead synchronous FIFO; head entry, level and flags are all registered.
// A push while full is accepted only together with a pop in the same cycle.
module booth_prod_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             do_push;
    logic             do_pop;

    // Next pointers, occupancy and head entry (with write-through bypass)
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = level;
        head_nxt   = '0;
        if (flush) begin
            do_push    = 1'b0;
            do_pop     = 1'b0;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            level_nxt  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            level_nxt = level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
        if (level_nxt != '0) begin
            if (do_push && (wr_ptr == rd_ptr_nxt)) begin
                head_nxt = wdata;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // Entry storage; no reset needed, validity is tracked by level
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, level, flags and the registered head entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            rdata  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
            full   <= (level_nxt == LVL_W'(DEPTH));
            empty  <= (level_nxt == '0);
            rdata  <= head_nxt;
        end
    end

endmodule

// File: rtl/booth_product_collector.sv
// Collects high/low result bytes from the byte-serial Booth multiplier,
// concatenates them into a signed product and queues it for the consumer.
// Optional macro BOOTH_COLLECT_FIT_EN adds prod_fits (product fits DATA_WIDTH).
module booth_product_collector
    import booth_collect_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       byte_valid,
    input  logic [DATA_WIDTH-1:0]      byte_data,
    input  logic                       flush,
    output logic                       prod_valid,
    input  logic                       prod_ready,
    output logic [2*DATA_WIDTH-1:0]    prod_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
`ifdef BOOTH_COLLECT_FIT_EN
    ,
    output logic                       prod_fits
`endif
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
`ifdef BOOTH_COLLECT_FIT_EN
    localparam int unsigned ENTRY_W = PROD_W + 1;
`else
    localparam int unsigned ENTRY_W = PROD_W;
`endif

    collect_state_t         state;
    logic [DATA_WIDTH-1:0]  hi_reg;
    logic                   push_req;
    logic                   pop_req;
    logic [ENTRY_W-1:0]     wdata;
    logic [ENTRY_W-1:0]     rdata;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Low byte completes a product; flush suppresses it
    always_comb begin
        push_req = 1'b0;
        pop_req  = 1'b0;
        if (!flush) begin
            push_req = byte_valid && (state == S_LOW);
        end
        pop_req = prod_ready && !fifo_empty;
    end

`ifdef BOOTH_COLLECT_FIT_EN
    // Product fits DATA_WIDTH when the high byte is a pure sign extension
    always_comb begin
        wdata = {(hi_reg == {DATA_WIDTH{byte_data[DATA_WIDTH-1]}}), hi_reg, byte_data};
    end

    assign prod_fits = rdata[ENTRY_W-1];
`else
    // Product is the two bytes concatenated unchanged
    always_comb begin
        wdata = {hi_reg, byte_data};
    end
`endif

    // Assembler FSM: latch high byte, then return to S_HIGH on the low byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_HIGH;
            hi_reg <= '0;
        end else if (flush) begin
            state  <= S_HIGH;
        end else if (byte_valid) begin
            case (state)
                S_HIGH: begin
                    hi_reg <= byte_data;
                    state  <= S_LOW;
                end
                S_LOW: begin
                    state  <= S_HIGH;
                end
                default: begin
                    state  <= S_HIGH;
                end
            endcase
        end
    end

    // Sticky drop flag: completed product found the FIFO full with no pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !pop_req) begin
            overflow <= 1'b1;
        end
    end

    booth_prod_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_req),
        .pop   (pop_req),
        .wdata (wdata),
        .rdata (rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign prod_valid = !fifo_empty;
    assign prod_data  = rdata[PROD_W-1:0];

endmodule

// File: tb/tb_booth_product_collector.sv
// Directed self-checking bench for booth_product_collector.
module tb_booth_product_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        flush = 1'b0;
    logic        prod_valid;
    logic        prod_ready = 1'b0;
    logic [15:0] prod_data;
    logic [2:0]  level;
    logic        overflow;
`ifdef BOOTH_COLLECT_FIT_EN
    logic        prod_fits;
`endif

    int checks = 0;
    int errors = 0;

    booth_product_collector #(
        .DATA_WIDTH (8),
        .DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .flush      (flush),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .level      (level),
        .overflow   (overflow)
`ifdef BOOTH_COLLECT_FIT_EN
        ,
        .prod_fits  (prod_fits)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        step();
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo);
        send_byte(hi);
        send_byte(lo);
    endtask

    task automatic pop_one();
        prod_ready = 1'b1;
        step();
        prod_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #2;
        check("rst_valid", 32'(prod_valid), 32'd0);
        check("rst_data", 32'(prod_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
`ifdef BOOTH_COLLECT_FIT_EN
        check("rst_fits", 32'(prod_fits), 32'd0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single product: -3 * 5 = 0xFFF1
        send_byte(8'hFF);
        check("single_hi_only_valid", 32'(prod_valid), 32'd0);
        send_byte(8'hF1);
        check("single_valid", 32'(prod_valid), 32'd1);
        check("single_data", 32'(prod_data), 32'hFFF1);
        check("single_level", 32'(level), 32'd1);
        pop_one();
        check("single_pop_valid", 32'(prod_valid), 32'd0);
        check("single_pop_level", 32'(level), 32'd0);
        check("single_pop_data", 32'(prod_data), 32'd0);

        // Ready while empty has no effect
        pop_one();
        check("empty_ready_level", 32'(level), 32'd0);

        // Fill and overflow
        for (int i = 1; i <= 4; i++) begin
            send_pair(8'h00, 8'(i));
        end
        check("fill_level", 32'(level), 32'd4);
        check("fill_head", 32'(prod_data), 32'h0001);
        check("fill_no_ovf", 32'(overflow), 32'd0);
        send_pair(8'h00, 8'h05);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", 32'(prod_valid), 32'd1);
            check("drain_data", 32'(prod_data), 32'(i));
            pop_one();
        end
        check("drain_empty", 32'(prod_valid), 32'd0);
        check("drain_level", 32'(level), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_clears_ovf", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        send_pair(8'h00, 8'h22);
        send_pair(8'h00, 8'h33);
        send_pair(8'h00, 8'h44);
        send_pair(8'h00, 8'h55);
        check("pp_full_level", 32'(level), 32'd4);
        send_byte(8'h12);
        byte_valid = 1'b1;
        byte_data  = 8'h34;
        prod_ready = 1'b1;
        step();
        byte_valid = 1'b0;
        prod_ready = 1'b0;
        check("pp_level", 32'(level), 32'd4);
        check("pp_no_ovf", 32'(overflow), 32'd0);
        check("pp_head", 32'(prod_data), 32'h0033);
        pop_one();
        check("pp_d1", 32'(prod_data), 32'h0044);
        pop_one();
        check("pp_d2", 32'(prod_data), 32'h0055);
        pop_one();
        check("pp_last", 32'(prod_data), 32'h1234);
        pop_one();
        check("pp_empty", 32'(prod_valid), 32'd0);

        // Flush mid-pair, byte in flush cycle ignored
        send_byte(8'h7F);
        flush      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        step();
        flush      = 1'b0;
        byte_valid = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_valid", 32'(prod_valid), 32'd0);
        // Next pair; low byte arrives with ready while empty (pop ignored)
        send_byte(8'h00);
        prod_ready = 1'b1;
        send_byte(8'h2A);
        prod_ready = 1'b0;
        check("flush_next_data", 32'(prod_data), 32'h002A);
        check("flush_next_level", 32'(level), 32'd1);
        pop_one();

        // Async reset mid-operation
        send_pair(8'h01, 8'h02);
        send_pair(8'h03, 8'h04);
        send_byte(8'h55);
        check("pre_rst_level", 32'(level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(prod_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        #1 rst_n = 1'b1;
        step();
        send_pair(8'hFF, 8'h80);
        check("post_rst_data", 32'(prod_data), 32'hFF80);
        check("post_rst_level", 32'(level), 32'd1);
        pop_one();

`ifdef BOOTH_COLLECT_FIT_EN
        // Fit indication follows the head entry
        send_pair(8'hFF, 8'h80);
        send_pair(8'h00, 8'h80);
        send_pair(8'h01, 8'h00);
        check("fit_ff80", 32'(prod_fits), 32'd1);
        pop_one();
        check("fit_0080_data", 32'(prod_data), 32'h0080);
        check("fit_0080", 32'(prod_fits), 32'd0);
        pop_one();
        check("fit_0100_data", 32'(prod_data), 32'h0100);
        check("fit_0100", 32'(prod_fits), 32'd0);
        pop_one();
        check("fit_empty", 32'(prod_fits), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
